// File: rtl/hbm_axi_txn_limiter.sv
// Outstanding-transaction limiter between the NoC and the HBM wrapper: gates AW/AR admission
// until HBM is calibrated, caps outstanding writes/reads, and drains/holds traffic on flush.

package hbm_axi_txn_limiter_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } hbm_ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } hbm_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } hbm_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } hbm_r_chan_t;

  typedef struct packed {
    hbm_ax_chan_t aw;
    logic         aw_valid;
    hbm_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    hbm_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } hbm_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    hbm_b_chan_t b;
    logic        b_valid;
    hbm_r_chan_t r;
    logic        r_valid;
  } hbm_rsp_t;

endpackage

// state | meaning
// INIT  | waiting for HBM calibration, AW/AR blocked
// RUN   | normal traffic, AW/AR admitted while under the outstanding limit
// DRAIN | flush requested, AW/AR blocked until all outstanding txns complete
// HALT  | drained, AW/AR blocked until flush is released
module hbm_axi_txn_limiter #(
  parameter type axi_req_t = hbm_axi_txn_limiter_pkg::hbm_req_t,
  parameter type axi_rsp_t = hbm_axi_txn_limiter_pkg::hbm_rsp_t,
  parameter int  MaxWrTxns = 8,
  parameter int  MaxRdTxns = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hbm_ready_i,
  input  logic       flush_i,
  input  axi_req_t   slv_req_i,
  output axi_rsp_t   slv_rsp_o,
  output axi_req_t   mst_req_o,
  input  axi_rsp_t   mst_rsp_i,
  output logic       flush_done_o,
  output logic [7:0] wr_cnt_o,
  output logic [7:0] rd_cnt_o,
  output logic       err_o
);

  localparam logic [7:0] MAX_WR = 8'(MaxWrTxns);
  localparam logic [7:0] MAX_RD = 8'(MaxRdTxns);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic       err_q, flush_done_q;
  logic       aw_en, ar_en;
  logic       aw_hs, b_hs, ar_hs, r_last_hs;
  logic       wr_err, rd_err;

  // Enables come from registered state/counts only, so no valid->ready loop is created
  assign aw_en = (state_q == RUN) && (wr_cnt_q < MAX_WR);
  assign ar_en = (state_q == RUN) && (rd_cnt_q < MAX_RD);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_en;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_en;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_en;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_en;
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
  assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (hbm_ready_i) state_d = RUN;
      RUN:     if (flush_i) state_d = DRAIN;
      DRAIN:   if ((wr_cnt_q == 8'd0) && (rd_cnt_q == 8'd0)) state_d = HALT;
      HALT:    if (!flush_i) state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // A simultaneous increment masks a decrement at zero, so it is not flagged as unsolicited
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_err   = 1'b0;
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
    end else if (b_hs && !aw_hs) begin
      if (wr_cnt_q == 8'd0) wr_err = 1'b1;
      else                  wr_cnt_d = wr_cnt_q - 8'd1;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_err   = 1'b0;
    if (ar_hs && !r_last_hs) begin
      rd_cnt_d = rd_cnt_q + 8'd1;
    end else if (r_last_hs && !ar_hs) begin
      if (rd_cnt_q == 8'd0) rd_err = 1'b1;
      else                  rd_cnt_d = rd_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= INIT;
      wr_cnt_q     <= 8'd0;
      rd_cnt_q     <= 8'd0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      err_q        <= err_q | wr_err | rd_err;
      flush_done_q <= (state_d == HALT);
    end
  end

  assign wr_cnt_o     = wr_cnt_q;
  assign rd_cnt_o     = rd_cnt_q;
  assign err_o        = err_q;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_hbm_axi_txn_limiter.sv
// Directed bench for hbm_axi_txn_limiter: init gating, limits, simultaneous events,
// multi-beat reads, flush sequencing, error flag and asynchronous reset.

module tb_hbm_axi_txn_limiter;
  import hbm_axi_txn_limiter_pkg::*;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       hbm_ready = 1'b0;
  logic       flush = 1'b0;
  hbm_req_t   slv_req, mst_req;
  hbm_rsp_t   slv_rsp, mst_rsp;
  logic       flush_done, err;
  logic [7:0] wr_cnt, rd_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         hs;

  always #5 clk_sys = ~clk_sys;

  hbm_axi_txn_limiter #(
    .axi_req_t(hbm_req_t),
    .axi_rsp_t(hbm_rsp_t),
    .MaxWrTxns(8),
    .MaxRdTxns(8)
  ) dut (
    .clk_i       (clk_sys),
    .rst_i       (rst),
    .hbm_ready_i (hbm_ready),
    .flush_i     (flush),
    .slv_req_i   (slv_req),
    .slv_rsp_o   (slv_rsp),
    .mst_req_o   (mst_req),
    .mst_rsp_i   (mst_rsp),
    .flush_done_o(flush_done),
    .wr_cnt_o    (wr_cnt),
    .rd_cnt_o    (rd_cnt),
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
    end
  endtask

  task automatic hbm_side_idle();
    mst_rsp          = '0;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
  endtask

  initial begin
    slv_req         = '0;
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;
    hbm_side_idle();

    // reset state
    tick(2);
    check("rst_wr_cnt", wr_cnt, 8'd0);
    check("rst_rd_cnt", rd_cnt, 8'd0);
    check("rst_err", err, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_aw_ready", slv_rsp.aw_ready, 1'b0);
    rst = 1'b0;

    // init gating: AW held off while HBM not ready
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h1000_0040;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mst_req.aw_valid && mst_rsp.aw_ready) hs++;
    end
    check("init_no_aw_hs", hs, 0);
    check("init_wr_cnt", wr_cnt, 8'd0);
    hbm_ready = 1'b1;
    tick();
    check("init_edge1_wr_cnt", wr_cnt, 8'd0);
    check("init_edge1_aw_ready", slv_rsp.aw_ready, 1'b1);
    hbm_ready = 1'b0;
    tick();
    check("init_edge2_wr_cnt", wr_cnt, 8'd1);
    check("aw_addr_pass", mst_req.aw.addr, 32'h1000_0040);

    // payload and W pass-through, ready_i ignored after INIT
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = 64'hDEAD_BEEF_0123_4567;
    mst_rsp.w_ready = 1'b0;
    #1;
    check("w_data_pass", mst_req.w.data, 64'hDEAD_BEEF_0123_4567);
    check("w_ready_pass", slv_rsp.w_ready, 1'b0);
    check("hbm_ready_ignored", slv_rsp.aw_ready, 1'b1);
    slv_req.w_valid = 1'b0;
    mst_rsp.w_ready = 1'b1;

    // write limit: 7 more AWs fill to 8, the next is refused
    tick(7);
    check("wlim_full", wr_cnt, 8'd8);
    check("wlim_aw_ready_blk", slv_rsp.aw_ready, 1'b0);
    check("wlim_aw_valid_blk", mst_req.aw_valid, 1'b0);
    tick(2);
    check("wlim_hold", wr_cnt, 8'd8);
    mst_rsp.b_valid = 1'b1;
    tick();
    mst_rsp.b_valid = 1'b0;
    check("wlim_after_b", wr_cnt, 8'd7);
    #1;
    check("wlim_aw_ready_reopen", slv_rsp.aw_ready, 1'b1);
    tick();
    check("wlim_ninth", wr_cnt, 8'd8);
    slv_req.aw_valid = 1'b0;

    // simultaneous AW + B at wr_cnt=3
    mst_rsp.b_valid = 1'b1;
    tick(5);
    check("sim_wr_pre", wr_cnt, 8'd3);
    slv_req.aw_valid = 1'b1;
    tick();
    check("sim_wr_same", wr_cnt, 8'd3);
    slv_req.aw_valid = 1'b0;
    tick(3);
    mst_rsp.b_valid = 1'b0;
    check("sim_wr_drained", wr_cnt, 8'd0);

    // simultaneous AR + R-last
    slv_req.ar_valid = 1'b1;
    tick();
    check("sim_rd_pre", rd_cnt, 8'd1);
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last  = 1'b1;
    tick();
    check("sim_rd_same", rd_cnt, 8'd1);
    slv_req.ar_valid = 1'b0;
    tick();
    mst_rsp.r_valid = 1'b0;
    check("sim_rd_drained", rd_cnt, 8'd0);

    // multi-beat read, len=3
    slv_req.ar_valid = 1'b1;
    slv_req.ar.len   = 8'd3;
    #1;
    check("ar_len_pass", mst_req.ar.len, 8'd3);
    tick();
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.last   = 1'b0;
    tick(3);
    check("mb_after_3_beats", rd_cnt, 8'd1);
    mst_rsp.r.last = 1'b1;
    #1;
    check("r_last_pass", slv_rsp.r.last, 1'b1);
    tick();
    mst_rsp.r_valid = 1'b0;
    check("mb_after_last", rd_cnt, 8'd0);

    // flush with 2 writes and 1 read outstanding
    slv_req.aw_valid = 1'b1;
    tick(2);
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b1;
    tick();
    slv_req.ar_valid = 1'b0;
    check("fl_wr_pre", wr_cnt, 8'd2);
    check("fl_rd_pre", rd_cnt, 8'd1);
    flush = 1'b1;
    tick();
    slv_req.aw_valid = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.w_valid  = 1'b1;
    #1;
    check("fl_aw_blocked", slv_rsp.aw_ready, 1'b0);
    check("fl_ar_blocked", mst_req.ar_valid, 1'b0);
    check("fl_w_flows", mst_req.w_valid, 1'b1);
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    mst_rsp.b_valid  = 1'b1;
    tick(2);
    mst_rsp.b_valid = 1'b0;
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last  = 1'b1;
    tick();
    mst_rsp.r_valid = 1'b0;
    check("fl_done_not_yet", flush_done, 1'b0);
    tick();
    check("fl_done", flush_done, 1'b1);
    slv_req.aw_valid = 1'b1;
    #1;
    check("fl_halt_aw_blocked", slv_rsp.aw_ready, 1'b0);
    slv_req.aw_valid = 1'b0;
    flush = 1'b0;
    tick();
    check("fl_done_clr", flush_done, 1'b0);
    slv_req.aw_valid = 1'b1;
    #1;
    check("fl_resume_aw_ready", slv_rsp.aw_ready, 1'b1);
    tick();
    slv_req.aw_valid = 1'b0;
    check("fl_resume_wr", wr_cnt, 8'd1);

    // unsolicited B sets sticky error
    mst_rsp.b_valid = 1'b1;
    tick();
    check("err_legit_b", err, 1'b0);
    tick();
    mst_rsp.b_valid = 1'b0;
    check("err_set", err, 1'b1);
    check("err_wr_zero", wr_cnt, 8'd0);
    tick();
    check("err_sticky", err, 1'b1);

    // asynchronous reset mid-burst
    slv_req.aw_valid = 1'b1;
    slv_req.ar_valid = 1'b1;
    tick(2);
    check("rb_wr_pre", wr_cnt, 8'd2);
    rst = 1'b1;
    hbm_side_idle();
    #1;
    check("rb_wr", wr_cnt, 8'd0);
    check("rb_rd", rd_cnt, 8'd0);
    check("rb_err", err, 1'b0);
    check("rb_flush_done", flush_done, 1'b0);
    check("rb_aw_ready", slv_rsp.aw_ready, 1'b0);
    check("rb_ar_valid", mst_req.ar_valid, 1'b0);
    tick();
    rst = 1'b0;
    tick(2);
    check("post_rst_blocked", wr_cnt, 8'd0);
    hbm_ready = 1'b1;
    tick();
    check("post_rst_edge1", wr_cnt, 8'd0);
    tick();
    check("post_rst_edge2", wr_cnt, 8'd1);
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hbm_axi_txn_limiter.md
HBM_AXI_TXN_LIMITER -- requirements
Module: hbm_axi_txn_limiter

Interface
REQ-001 SHALL have parameter axi_req_t, default logic, meaning the AXI request struct on both ports (floo_narrow_wide_pkg wide or narrow out type).
REQ-002 SHALL have parameter axi_rsp_t, default logic, meaning the AXI response struct on both ports.
REQ-003 SHALL have parameter MaxWrTxns, default 8, meaning the maximum number of outstanding writes (AW accepted, B not yet returned); legal range 1..255.
REQ-004 SHALL have parameter MaxRdTxns, default 8, meaning the maximum number of outstanding reads (AR accepted, last R not yet returned); legal range 1..255.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL be in this domain.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port hbm_ready_i, input, 1 bit: HBM controller initialisation/calibration done.
REQ-008 SHALL have port flush_i, input, 1 bit: level request to drain and hold traffic.
REQ-009 SHALL have port slv_req_i, input, axi_req_t: from the network interface.
REQ-010 SHALL have port slv_rsp_o, output, axi_rsp_t: to the network interface.
REQ-011 SHALL have port mst_req_o, output, axi_req_t: to the HBM wrapper.
REQ-012 SHALL have port mst_rsp_i, input, axi_rsp_t: from the HBM wrapper.
REQ-013 SHALL have port flush_done_o, output, 1 bit: high while in HALT.
REQ-014 SHALL have port wr_cnt_o, output, 8 bits: outstanding write count.
REQ-015 SHALL have port rd_cnt_o, output, 8 bits: outstanding read count.
REQ-016 SHALL have port err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-017 The FSM SHALL have the states INIT, RUN, DRAIN and HALT.
REQ-018 The FSM SHALL have the following transitions: INIT->RUN when hbm_ready_i=1; RUN->DRAIN when flush_i=1; DRAIN->HALT when wr_cnt=0 and rd_cnt=0; HALT->RUN when flush_i=0. Each transition takes one cycle.
REQ-019 After INIT has been left, hbm_ready_i SHALL be ignored.
REQ-020 aw_en SHALL be (state==RUN) and (wr_cnt<MaxWrTxns), decoded from registered state only; ar_en SHALL be the same with rd_cnt and MaxRdTxns.
REQ-021 mst_req_o.aw_valid SHALL be slv_req_i.aw_valid and aw_en; slv_rsp_o.aw_ready SHALL be mst_rsp_i.aw_ready and aw_en. The AR channel SHALL do the same using ar_en.
REQ-022 All other fields and channels (AW/AR payload, W, B, R) SHALL pass through combinationally, with zero latency and unmodified.
REQ-023 W SHALL never be gated, so that data for already-accepted AWs always drains.
REQ-024 wr_cnt SHALL increment on an AW handshake at mst_req_o; it SHALL decrement on a B handshake (b_valid and b_ready).
REQ-025 rd_cnt SHALL increment on an AR handshake; it SHALL decrement on an R handshake with r.last=1.
REQ-026 An increment and a decrement in the same cycle SHALL leave the count unchanged.
REQ-027 The count SHALL never exceed its Max value, because of the gating in REQ-020.
REQ-028 A decrement while the count is 0 (unsolicited B or R-last) SHALL leave the count at 0 and set err_o; err_o SHALL stay set until reset.
REQ-029 If flush_i is asserted during INIT, the flush SHALL take effect after RUN is entered.
REQ-030 If flush_i deasserts during DRAIN, draining SHALL still complete to HALT, and HALT SHALL then exit to RUN on the next cycle.
REQ-031 wr_cnt_o, rd_cnt_o and flush_done_o SHALL be register-driven.
REQ-032 The only combinational paths SHALL be slv->mst and mst->slv, with no valid->ready loop added.

Reset
REQ-033 On rst_i=1, the block SHALL enter state INIT with wr_cnt=0, rd_cnt=0, err_o=0, flush_done_o=0; aw_en and ar_en SHALL be 0 (AW/AR blocked).
REQ-034 Reset asserted mid-transaction SHALL discard the counts; the bench SHALL also reset the HBM side.
REQ-035 After reset releases, the first AW/AR SHALL be accepted no earlier than the cycle after hbm_ready_i is sampled at 1.

Verification
REQ-036 Init gating: hold hbm_ready_i=0 with aw_valid=1 for 10 cycles -> no AW handshake; raise hbm_ready_i -> AW handshake on cycle 2, wr_cnt_o=1.
REQ-037 Write limit: MaxWrTxns=8, issue 9 AWs with B stalled -> 8 accepted, 9th aw_ready=0; return one B -> wr_cnt=7, then the 9th is accepted -> wr_cnt=8.
REQ-038 Simultaneous events: AW handshake and B handshake in the same cycle at wr_cnt=3 -> wr_cnt stays 3; AR handshake and R-last in the same cycle -> rd_cnt unchanged.
REQ-039 Multi-beat read: AR len=3 -> rd_cnt=1 through 3 non-last beats, and 0 after the last beat.
REQ-040 Flush: with 2 writes and 1 read outstanding, assert flush_i -> new AW/AR blocked, W still flows; after the final B/R-last, flush_done_o=1 on the next cycle; drop flush_i -> flush_done_o=0 and traffic resumes.
REQ-041 Error and reset: inject a B at wr_cnt=0 -> err_o=1 and wr_cnt=0; assert rst_i mid-burst -> all outputs return to their reset values immediately.
